// File: rtl/cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
//   cfg_state_t    sequencer FSM states
//   CFG_END_MARK   ROM word that terminates the table
//   CFG_DELAY_REG  ROM high byte that marks a timed delay entry
//   is_busy_state  true for every state except idle and done
package cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StSend,
        StWaitAck,
        StDelay,
        StDone
    } cfg_state_t;

    localparam logic [15:0] CFG_END_MARK  = 16'hFFFF;
    localparam logic [7:0]  CFG_DELAY_REG = 8'hFF;

    function automatic logic is_busy_state(input cfg_state_t s);
        return !((s == StIdle) || (s == StDone));
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for ROM delay markers.
//   i_clk      system clock
//   i_rst      asynchronous, active-high reset (counter cleared)
//   i_load     load DELAY_CYCLES-1; takes priority over counting
//   o_expired  counter has reached zero
// After a load the counter spends exactly DELAY_CYCLES cycles before (and including) the
// cycle in which o_expired is seen, so the owner stays DELAY_CYCLES cycles in its wait state.
module cfg_delay_timer #(
    parameter int unsigned DELAY_CYCLES = 240_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expired
);

    localparam int unsigned   CW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(DELAY_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule

// File: rtl/cfg_sequencer.sv
// Walks the camera configuration ROM from address 0 and issues each {reg,value} entry to the
// SCCB write master. 16'hFFFF ends the table; 16'hFFxx inserts a DELAY_CYCLES wait.
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_start                       begin/restart; honoured only in idle or done
//   o_busy, o_done                status, registered, never both high
//   o_rom_addr, i_rom_data        ROM address out, registered ROM word in (1-cycle latency)
//   o_sccb_valid, i_sccb_ready    write request handshake
//   o_sccb_reg, o_sccb_data       register address / value, stable while valid
//   i_sccb_done                   write completed pulse, only honoured while waiting for it
module cfg_sequencer
    import cfg_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 240_000,
    parameter int unsigned ROM_AW       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_valid,
    input  logic              i_sccb_ready,
    output logic [7:0]        o_sccb_reg,
    output logic [7:0]        o_sccb_data,
    input  logic              i_sccb_done
);

    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

    cfg_state_t        state_q, state_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, done_q;
    logic              delay_load, delay_expired, advance;

    cfg_delay_timer #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_delay_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (delay_load),
        .o_expired(delay_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        reg_d      = reg_q;
        data_d     = data_q;
        delay_load = 1'b0;
        advance    = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (i_rom_data == CFG_END_MARK) begin
                    state_d = StDone;
                end else if (i_rom_data[15:8] == CFG_DELAY_REG) begin
                    state_d    = StDelay;
                    delay_load = 1'b1;
                end else begin
                    reg_d   = i_rom_data[15:8];
                    data_d  = i_rom_data[7:0];
                    valid_d = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (i_sccb_ready) begin
                    valid_d = 1'b0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: advance = i_sccb_done;
            StDelay:   advance = delay_expired;
            default:   state_d = StIdle;
        endcase

        // A table without an end marker stops at the last address instead of wrapping.
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                state_d = StDone;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            valid_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            busy_q  <= is_busy_state(state_d);
            done_q  <= (state_d == StDone);
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_rom_addr   = addr_q;
    assign o_sccb_valid = valid_q;
    assign o_sccb_reg   = reg_q;
    assign o_sccb_data  = data_q;

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer with a registered ROM model and an SCCB master BFM.
module tb_cfg_sequencer;

    localparam int unsigned DELAY = 16;

    logic        clk, rst, start;
    logic        busy, done;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid, sccb_ready, sccb_done;
    logic [7:0]  sccb_reg, sccb_data;

    cfg_sequencer #(
        .DELAY_CYCLES(DELAY),
        .ROM_AW      (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_sccb_valid(sccb_valid),
        .i_sccb_ready(sccb_ready),
        .o_sccb_reg  (sccb_reg),
        .o_sccb_data (sccb_data),
        .i_sccb_done (sccb_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: registered read, data valid one cycle after the address.
    logic [15:0] rom [256];
    always @(posedge clk or posedge rst) begin
        if (rst) rom_data <= '0;
        else     rom_data <= rom[rom_addr];
    end

    // Write monitor: an accepted request is valid && ready at a rising edge.
    logic [15:0] wr_log[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          overlap = 0;
    always @(posedge clk) begin
        cyc++;
        if (sccb_valid && sccb_ready) begin
            wr_log.push_back({sccb_reg, sccb_data});
            wr_cyc.push_back(cyc);
            acc_cnt++;
        end
    end
    always @(negedge clk) if (busy && done) overlap++;

    // SCCB master BFM: drops ready on accept, pulses done bfm_lat cycles later.
    logic bfm_block = 1'b0;
    logic inj_done  = 1'b0;
    int   bfm_lat   = 3;
    int   bfm_seen  = 0;
    int   lat_cnt   = 0;
    initial begin
        sccb_ready = 1'b1;
        sccb_done  = 1'b0;
        forever begin
            @(negedge clk);
            sccb_done = inj_done;
            inj_done  = 1'b0;
            if (rst) begin
                sccb_ready = !bfm_block;
                lat_cnt    = 0;
                bfm_seen   = acc_cnt;
            end else if (acc_cnt != bfm_seen) begin
                bfm_seen   = acc_cnt;
                sccb_ready = 1'b0;
                lat_cnt    = bfm_lat;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) sccb_done = 1'b1;
            end else begin
                sccb_ready = !bfm_block;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wr_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 16'h0000;
    endfunction

    function automatic logic [26:0] out_vec();
        return {busy, done, sccb_valid, rom_addr, sccb_reg, sccb_data};
    endfunction

    task automatic rom_fill_end();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic rom_load_basic();
        rom_fill_end();
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    task automatic clear_log();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done, 1'b1);
    endtask

    task automatic wait_writes(input int cnt, input int budget, input string tag);
        int n = 0;
        while (wr_log.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, wr_log.size(), cnt);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int stable;
    int bad;
    int n;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        rom_load_basic();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_vec(), '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_after_release", {busy, done}, 2'b00);

        // Two writes separated by a delay marker, then end marker.
        clear_log();
        pulse_start();
        check_eq("busy_after_start", busy, 1'b1);
        wait_done(300, "basic_done");
        check_eq("basic_count", wr_log.size(), 2);
        check_eq("basic_wr0", wr_at(0), 16'h1280);
        check_eq("basic_wr1", wr_at(1), 16'h1204);
        // ack at +4 (3-cycle BFM latency), fetch/decode 2, delay 16, fetch/decode/send 3
        if (wr_cyc.size() == 2) check_eq("basic_gap", wr_cyc[1] - wr_cyc[0], 25);
        else                    check_eq("basic_gap_present", wr_cyc.size(), 2);
        check_eq("basic_busy_low", busy, 1'b0);
        check_eq("basic_addr_end", rom_addr, 8'd3);

        // Backpressure: ready low for 10 cycles, spurious done in fetch, start during send.
        bfm_block = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
        start = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!sccb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (sccb_valid && !sccb_ready && sccb_reg == 8'h12 && sccb_data == 8'h80) stable++;
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("hold_stable", stable, 10);
        check_eq("hold_no_accept", wr_log.size(), 0);
        bfm_block = 1'b0;
        wait_done(300, "hold_done");
        check_eq("hold_count", wr_log.size(), 2);
        check_eq("hold_wr0", wr_at(0), 16'h1280);
        check_eq("hold_wr1", wr_at(1), 16'h1204);

        // End marker at entry 0: done two cycles after fetch, no writes.
        rom_fill_end();
        clear_log();
        pulse_start();
        check_eq("empty_fetch_busy", {busy, done}, 2'b10);
        @(negedge clk);
        check_eq("empty_decode_busy", {busy, done}, 2'b10);
        @(negedge clk);
        check_eq("empty_done", {busy, done}, 2'b01);
        check_eq("empty_no_writes", wr_log.size(), 0);

        // Full table without end marker: 256 writes, stops at 255.
        for (int i = 0; i < 256; i++) rom[i] = {8'(i % 128), 8'(i)};
        clear_log();
        pulse_start();
        wait_done(4000, "full_done");
        check_eq("full_count", wr_log.size(), 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_at(i) !== {8'(i % 128), 8'(i)}) bad++;
        check_eq("full_order", bad, 0);
        check_eq("full_addr", rom_addr, 8'd255);
        repeat (5) @(negedge clk);
        check_eq("full_no_wrap", {done, rom_addr}, {1'b1, 8'd255});
        check_eq("full_count_after", wr_log.size(), 256);

        // Reset during wait-for-ack.
        rom_load_basic();
        clear_log();
        pulse_start();
        wait_writes(1, 50, "rst_ack_first_write");
        check_eq("rst_ack_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_eq("rst_ack_outputs", out_vec(), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset during delay.
        clear_log();
        pulse_start();
        wait_writes(1, 50, "rst_dly_first_write");
        repeat (10) @(negedge clk);
        check_eq("rst_dly_before", {busy, sccb_valid, rom_addr}, {1'b1, 1'b0, 8'd1});
        #2 rst = 1'b1;
        #1 check_eq("rst_dly_outputs", out_vec(), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Rerun from address 0 after reset.
        clear_log();
        pulse_start();
        wait_done(300, "rerun_done");
        check_eq("rerun_count", wr_log.size(), 2);
        check_eq("rerun_wr0", wr_at(0), 16'h1280);
        check_eq("rerun_wr1", wr_at(1), 16'h1204);

        check_eq("busy_done_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
